seq_restoring_divider: RTL

- Multi-cycle unsigned restoring divider. It is the inverse companion of the team's START/READY shift-add multiplier.
- Takes a DW-bit dividend and a VW-bit divisor and produces a quotient and remainder, one quotient bit per clock.
- Uses the same START/READY handshake as the multiplier, so both can sit side by side in the arithmetic datapath lab.

---
 rtl/seq_restoring_divider.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with START/READY handshake.
// Produces one quotient bit per clock: Q = A / B, R = A % B.
// Optional feature macro: SEQDIV_DIVZ_EN (zero divisor short-cuts to DONE with DIVZ=1).
module seq_restoring_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          START,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          READY,
  output logic          BUSY,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          DIVZ
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [DW-1:0] dvd_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   rem_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          busy_q;
  logic          divz_q;

  logic [VW:0]   rem_shift;
  logic [VW:0]   rem_next;
  logic          rem_fits;
  logic          unused_rem_msb;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
    rem_fits  = (rem_shift >= {1'b0, dvs_q});
    rem_next  = rem_fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  end

  // The remainder MSB only ever carries the transient compare bit; it is shifted out.
  assign unused_rem_msb = rem_q[VW];

  // Control FSM and datapath registers, outputs registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (START) begin
            dvd_q   <= A;
            dvs_q   <= B;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= CW'(DW);
            state_q <= StRun;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            divz_q  <= 1'b0;
`ifdef SEQDIV_DIVZ_EN
            // Zero divisor: report the all-ones/low-bits result at once.
            if (B == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              divz_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= {1'b0, A[VW-1:0]};
              cnt_q   <= '0;
            end
`endif
          end
        end
        StRun: begin
          dvd_q <= dvd_q << 1;
          rem_q <= rem_next;
          quo_q <= {quo_q[DW-2:0], rem_fits};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign Q     = quo_q;
  assign R     = rem_q[VW-1:0];
`ifdef SEQDIV_DIVZ_EN
  assign DIVZ  = divz_q;
`else
  assign DIVZ  = 1'b0;
  logic unused_divz;
  assign unused_divz = divz_q;
`endif

endmodule
